// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the 8x10 FIFO controller.
package fifo_pkg;

    localparam int DATA_W = 10;
    localparam int PTR_W  = 3;
    localparam int ADD_W  = 4;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 2 ** PTR_W;

    // Occupancy value that means "every slot holds a word".
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // What the occupancy counter does on the next edge.
    typedef enum logic [1:0] {
        OCC_HOLD = 2'd0,
        OCC_INC  = 2'd1,
        OCC_DEC  = 2'd2
    } occ_op_e;

    // Memory address ports are wider than the pointers; upper bits are zero.
    function automatic logic [ADD_W-1:0] ptr_to_add(input logic [PTR_W-1:0] ptr);
        return {{(ADD_W-PTR_W){1'b0}}, ptr};
    endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrap-around pointer: advances by one when inc is high, wraps to zero
// naturally through its W-bit width.
module fifo_ptr_cnt
    import fifo_pkg::*;
#(
    parameter int W = PTR_W
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_reg;

    // Pointer register, cleared asynchronously so both sides restart at slot 0.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr_reg <= '0;
        end else if (inc) begin
            ptr_reg <= ptr_reg + W'(1);
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_ctrl.sv
// Control side of the 8x10 FIFO: accepts push/pop requests, drives the
// memory strobes and addresses, tracks occupancy and raises status flags.
module fifo_ctrl
    import fifo_pkg::*;
(
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    input  logic [CNT_W-1:0]  umbral_af,
    input  logic [CNT_W-1:0]  umbral_ae,
    output logic              wr_en,
    output logic [ADD_W-1:0]  wr_add,
    output logic [DATA_W-1:0] data_wr,
    output logic              rd_en,
    output logic [ADD_W-1:0]  rd_add,
    input  logic [DATA_W-1:0] data_out_mem,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              error
);

    logic                     pop_ok;
    logic                     push_ok;
    logic [CNT_W-1:0]         count_reg;
    logic [CNT_W-1:0]         count_next;
    occ_op_e                  occ_op;
    logic                     error_reg;
    logic                     error_next;
    logic                     valid_reg;
    logic [DATA_W-1:0]        hold_reg;

    // Index 0 is the write pointer, index 1 the read pointer.
    logic [1:0]               ptr_inc;
    logic [1:0][PTR_W-1:0]    ptr_val;

    // Flags come straight from the registered count, no extra latency.
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == CNT_FULL);
    assign almost_full  = (count_reg >= umbral_af);
    assign almost_empty = (count_reg <= umbral_ae);

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when paired with a successful pop.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign ptr_inc[0] = push_ok;
    assign ptr_inc[1] = pop_ok;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
            fifo_ptr_cnt #(
                .W (PTR_W)
            ) u_ptr (
                .clk     (clk),
                .reset_L (reset_L),
                .inc     (ptr_inc[gi]),
                .ptr     (ptr_val[gi])
            );
        end
    endgenerate

    assign wr_en   = push_ok;
    assign rd_en   = pop_ok;
    assign wr_add  = ptr_to_add(ptr_val[0]);
    assign rd_add  = ptr_to_add(ptr_val[1]);
    assign data_wr = data_in;

    // Decide whether occupancy grows, shrinks or holds this cycle.
    always_comb begin
        occ_op = OCC_HOLD;
        if (push_ok && !pop_ok) begin
            occ_op = OCC_INC;
        end else if (!push_ok && pop_ok) begin
            occ_op = OCC_DEC;
        end
    end

    // Next occupancy value from the selected operation.
    always_comb begin
        count_next = count_reg;
        case (occ_op)
            OCC_INC: count_next = count_reg + CNT_W'(1);
            OCC_DEC: count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Any rejected request (overflow or underflow) latches the error.
    always_comb begin
        error_next = error_reg | (push & ~push_ok) | (pop & ~pop_ok);
    end

    // Occupancy, sticky error and one-cycle read-valid pipeline.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count_reg <= '0;
            error_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            error_reg <= error_next;
            valid_reg <= pop_ok;
        end
    end

    // Keep the last delivered word so data_out holds between reads.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            hold_reg <= '0;
        end else if (valid_reg) begin
            hold_reg <= data_out_mem;
        end
    end

    // The memory answers one cycle after rd_en; pass that word through while
    // valid, otherwise show the held value.
    assign data_out  = valid_reg ? data_out_mem : hold_reg;
    assign valid_out = valid_reg;
    assign error     = error_reg;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl paired with a simple 8x10 read-before-write memory.
module tb_fifo_ctrl;

    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [9:0]  data_in = '0;
    logic [3:0]  umbral_af = 4'd6;
    logic [3:0]  umbral_ae = 4'd2;
    logic        wr_en, rd_en;
    logic [3:0]  wr_add, rd_add;
    logic [9:0]  data_wr, data_out_mem, data_out;
    logic        valid_out, full, empty, almost_full, almost_empty, error;

    logic [9:0]  mem [8];

    int tests_run = 0;
    int tests_failed = 0;

    // Reference state
    int          m_count, m_wr, m_rd;
    bit          m_err, m_pend;
    logic [9:0]  m_last;
    logic [9:0]  m_q [$];

    fifo_ctrl dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .umbral_af    (umbral_af),
        .umbral_ae    (umbral_ae),
        .wr_en        (wr_en),
        .wr_add       (wr_add),
        .data_wr      (data_wr),
        .rd_en        (rd_en),
        .rd_add       (rd_add),
        .data_out_mem (data_out_mem),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Memory block: registered read, old word returned on a same-address write.
    always @(posedge clk) begin
        if (rd_en) data_out_mem <= mem[rd_add[2:0]];
        if (wr_en) mem[wr_add[2:0]] <= data_wr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_wr    = 0;
        m_rd    = 0;
        m_err   = 1'b0;
        m_pend  = 1'b0;
        m_last  = '0;
        m_q.delete();
    endtask

    // One clock cycle of stimulus; checks the state left by the previous edge
    // and the strobes produced for this request.
    task automatic cycle(input bit p, input logic [9:0] d, input bit q);
        bit pop_ok, push_ok;
        @(negedge clk);
        push = p; data_in = d; pop = q;
        #1;
        check("empty",        32'(empty),        32'(m_count == 0));
        check("full",         32'(full),         32'(m_count == 8));
        check("almost_full",  32'(almost_full),  32'(m_count >= 6));
        check("almost_empty", 32'(almost_empty), 32'(m_count <= 2));
        check("error",        32'(error),        32'(m_err));
        check("valid_out",    32'(valid_out),    32'(m_pend));
        check("data_out",     32'(data_out),     32'(m_last));
        pop_ok  = q && (m_count != 0);
        push_ok = p && ((m_count != 8) || pop_ok);
        check("wr_en", 32'(wr_en), 32'(push_ok));
        check("rd_en", 32'(rd_en), 32'(pop_ok));
        if (push_ok) check("wr_add", 32'(wr_add), 32'(m_wr));
        if (pop_ok)  check("rd_add", 32'(rd_add), 32'(m_rd));
        if (pop_ok) m_last = m_q.pop_front();
        m_pend = pop_ok;
        if (push_ok) m_q.push_back(d);
        if ((p && !push_ok) || (q && !pop_ok)) m_err = 1'b1;
        m_count = m_count + int'(push_ok) - int'(pop_ok);
        m_wr = (m_wr + int'(push_ok)) % 8;
        m_rd = (m_rd + int'(pop_ok)) % 8;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_L = 1'b0; push = 1'b0; pop = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #2;
        check("rst_empty",        32'(empty),        32'(1));
        check("rst_almost_empty", 32'(almost_empty), 32'(1));
        check("rst_full",         32'(full),         32'(0));
        check("rst_almost_full",  32'(almost_full),  32'(0));
        check("rst_valid_out",    32'(valid_out),    32'(0));
        check("rst_data_out",     32'(data_out),     32'(0));
        check("rst_error",        32'(error),        32'(0));
        @(negedge clk);
        reset_L = 1'b1;

        // Fill with 0x101..0x108; wr_add walks 0..7
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 10'(32'h101 + i), 1'b0);
            check("fill_wr_add", 32'(wr_add), 32'(i));
        end
        cycle(1'b0, '0, 1'b0);
        check("fill_full",  32'(full),        32'(1));
        check("fill_af",    32'(almost_full), 32'(1));
        check("fill_error", 32'(error),       32'(0));

        // Drain 8 consecutive pops
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        check("drain_last", 32'(data_out), 32'h108);
        check("drain_empty", 32'(empty), 32'(1));
        cycle(1'b0, '0, 1'b0);

        // 12 pushes with 8 interleaved pops: rd pointer wraps 7->0
        for (int i = 0; i < 12; i++) cycle(1'b1, 10'(32'h200 + i), (i % 3) != 0);
        // Top up to full
        for (int i = 0; i < 4; i++) cycle(1'b1, 10'(32'h300 + i), 1'b0);
        cycle(1'b1, 10'h3FF, 1'b1);
        check("full_pp_same_add", 32'(wr_add), 32'(rd_add));
        check("full_pp_wr_en",    32'(wr_en),  32'(1));
        cycle(1'b0, '0, 1'b0);
        check("full_pp_oldest", 32'(data_out), 32'h208);
        check("full_pp_full",   32'(full),     32'(1));
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        check("full_pp_3ff", 32'(data_out), 32'h3FF);
        check("full_pp_err", 32'(error),    32'(0));

        // Underflow
        cycle(1'b0, '0, 1'b1);
        check("uf_rd_en", 32'(rd_en), 32'(0));
        cycle(1'b0, '0, 1'b0);
        check("uf_error", 32'(error), 32'(1));
        apply_reset();

        // Push and pop on empty: push taken, pop rejected
        cycle(1'b1, 10'h155, 1'b1);
        check("ep_wr_en", 32'(wr_en), 32'(1));
        check("ep_rd_en", 32'(rd_en), 32'(0));
        cycle(1'b0, '0, 1'b0);
        check("ep_error", 32'(error), 32'(1));
        check("ep_empty", 32'(empty), 32'(0));
        apply_reset();

        // Overflow on 9th push
        for (int i = 0; i < 8; i++) cycle(1'b1, 10'(32'h0A0 + i), 1'b0);
        cycle(1'b1, 10'h2AA, 1'b0);
        check("of_wr_en", 32'(wr_en), 32'(0));
        cycle(1'b0, '0, 1'b0);
        check("of_error", 32'(error), 32'(1));
        cycle(1'b0, '0, 1'b0);

        // Three pops leave count=5 with a read in flight, then async reset
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        @(posedge clk);
        #3;
        check("inflight_valid", 32'(valid_out), 32'(1));
        reset_L = 1'b0; pop = 1'b0; push = 1'b0;
        #1;
        check("arst_empty", 32'(empty),     32'(1));
        check("arst_valid", 32'(valid_out), 32'(0));
        check("arst_error", 32'(error),     32'(0));
        check("arst_data",  32'(data_out),  32'(0));
        model_reset();
        @(negedge clk);
        reset_L = 1'b1;
        cycle(1'b1, 10'h111, 1'b0);
        check("arst_wr_add", 32'(wr_add), 32'(0));
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        check("arst_readback", 32'(data_out), 32'h111);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
